capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the frame-count and frames-done fields.
REQ-002 SHALL have parameter TMO_W, default 32: width of the interval and timeout fields.
REQ-003 SHALL use one clock and an asynchronous, active-low reset. All logic is on sys_clk.
REQ-004 SHALL have port sys_clk  in  1  system clock.
REQ-005 SHALL have port sys_rst_n  in  1  async active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a sequence.
REQ-007 SHALL have port abort  in  1  one-cycle pulse that ends a sequence immediately.
REQ-008 SHALL have port frame_count  in  CNT_W  frames to capture; 0 means continuous.
REQ-009 SHALL have port interval_cycles  in  TMO_W  gap from a capture_end rise to the next capture.
REQ-010 SHALL have port timeout_cycles  in  TMO_W  per-frame watchdog limit; 0 disables the watchdog.
REQ-011 SHALL have port new_frame  in  1  frame-start pulse from the camera capture controller.
REQ-012 SHALL have port capture_end  in  1  level from the capture controller; cleared by new_frame.
REQ-013 SHALL have port capture  out  1  one-cycle request to the capture controller.
REQ-014 SHALL have port busy  out  1  high from the ARM state through the GAP state.
REQ-015 SHALL have port done  out  1  one-cycle pulse when a sequence completes.
REQ-016 SHALL have port frames_done  out  CNT_W  count of completed frames in the current or last sequence.
REQ-017 SHALL have port timeout_err  out  1  sticky watchdog-error flag.

Function
REQ-018 SHALL register all outputs.
REQ-019 SHALL implement the states IDLE, ARM, WAIT_START, WAIT_END and GAP.
REQ-020 SHALL, in IDLE on start, latch frame_count, interval_cycles and timeout_cycles, clear frames_done and timeout_err, and go to ARM.
REQ-021 SHALL assert capture for exactly the one cycle spent in ARM, so that a start sampled at edge t gives capture high at t+1; ARM then goes to WAIT_START.
REQ-022 SHALL, in WAIT_START, wait for new_frame and then go to WAIT_END; a capture_end level left over from a previous frame SHALL be ignored.
REQ-023 SHALL, in WAIT_END, detect a 0->1 transition of capture_end (registered copy of the previous value), increment frames_done, and then:
  - if the latched count is nonzero and frames_done+1 equals it: go to IDLE and pulse done the same cycle;
  - else if the latched interval is 0: go to ARM;
  - else: go to GAP.
REQ-024 SHALL hold GAP for exactly the latched interval_cycles cycles and then go to ARM.
REQ-025 SHALL run the watchdog counter in WAIT_START and WAIT_END, restarting it on entry to WAIT_START; when the latched timeout is nonzero and the count reaches it, the block SHALL set timeout_err and go to IDLE with no done pulse.
REQ-026 SHALL make abort take priority over all other events: next state IDLE, no done pulse, no capture, frames_done held.
REQ-027 SHALL ignore start while busy is high.
REQ-028 SHALL let frames_done wrap modulo 2^CNT_W in continuous mode.
REQ-029 SHALL let a capture_end rise win over a watchdog expiry when both occur in the same cycle.
REQ-030 SHALL use only the latched configuration mid-sequence; configuration input changes take effect at the next start.

Reset
REQ-031 SHALL, on sys_rst_n low, immediately force state IDLE and set capture, busy, done, frames_done and timeout_err to 0, including mid-sequence; all counters and the registered copy of capture_end SHALL clear.
REQ-032 SHALL restart only on a new start after reset deassertion.

Verification
REQ-033 frame_count=3, interval=10, camera model responds -> 3 capture pulses; each capture follows its preceding capture_end rise by 11 cycles (GAP held 10 cycles, then ARM); one done pulse; frames_done=3; busy low afterwards.
REQ-034 timeout=100, no new_frame -> timeout_err=1 exactly 100 cycles after WAIT_START entry; busy=0; done never pulses; timeout_err clears on the next start.
REQ-035 frame_count=0 -> continuous captures; abort issued after the 5th capture_end rise -> IDLE next cycle, frames_done=5, no done pulse.
REQ-036 capture_end held high before start -> no frame is counted until new_frame followed by a fresh capture_end rise.
REQ-037 start pulsed while busy -> ignored, configuration unchanged.
REQ-038 sys_rst_n asserted during WAIT_END -> all outputs 0 asynchronously.
REQ-039 capture_end rise in the same cycle as watchdog expiry -> frame counted and timeout_err stays 0.

Source files
------------

// File: rtl/capture_sequencer.sv
// Sequences camera frame captures: issues capture requests, waits for each frame to finish,
// spaces frames by a programmable gap and guards every frame with an optional watchdog.
module capture_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] frame_count,
    input  logic [TMO_W-1:0] interval_cycles,
    input  logic [TMO_W-1:0] timeout_cycles,
    input  logic             new_frame,
    input  logic             capture_end,
    output logic             capture,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_done,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitStart,
        StWaitEnd,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_cfg_q, cnt_cfg_d;
    logic [TMO_W-1:0] ivl_cfg_q, ivl_cfg_d;
    logic [TMO_W-1:0] tmo_cfg_q, tmo_cfg_d;
    logic [TMO_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             ce_prev_q;
    logic             capture_q, capture_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] frames_done_q, frames_done_d;
    logic             timeout_err_q, timeout_err_d;

    logic             ce_rise;
    logic             wd_expire;
    logic [CNT_W-1:0] fd_inc;

    assign ce_rise   = capture_end & ~ce_prev_q;
    assign wd_expire = (tmo_cfg_q != '0) && (wd_cnt_q == tmo_cfg_q - TMO_W'(1));
    assign fd_inc    = frames_done_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_cfg_d     = cnt_cfg_q;
        ivl_cfg_d     = ivl_cfg_q;
        tmo_cfg_d     = tmo_cfg_q;
        gap_cnt_d     = gap_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        frames_done_d = frames_done_q;
        timeout_err_d = timeout_err_q;
        done_d        = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_cfg_d     = frame_count;
                        ivl_cfg_d     = interval_cycles;
                        tmo_cfg_d     = timeout_cycles;
                        frames_done_d = '0;
                        timeout_err_d = 1'b0;
                        state_d       = StArm;
                    end
                end
                StArm: begin
                    wd_cnt_d = '0;
                    state_d  = StWaitStart;
                end
                StWaitStart: begin
                    wd_cnt_d = wd_cnt_q + TMO_W'(1);
                    if (new_frame) begin
                        state_d = StWaitEnd;
                    end else if (wd_expire) begin
                        timeout_err_d = 1'b1;
                        state_d       = StIdle;
                    end
                end
                StWaitEnd: begin
                    wd_cnt_d = wd_cnt_q + TMO_W'(1);
                    // A finished frame beats a watchdog expiry in the same cycle
                    if (ce_rise) begin
                        frames_done_d = fd_inc;
                        if ((cnt_cfg_q != '0) && (fd_inc == cnt_cfg_q)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else if (ivl_cfg_q == '0) begin
                            state_d = StArm;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = StGap;
                        end
                    end else if (wd_expire) begin
                        timeout_err_d = 1'b1;
                        state_d       = StIdle;
                    end
                end
                StGap: begin
                    gap_cnt_d = gap_cnt_q + TMO_W'(1);
                    if (gap_cnt_q == ivl_cfg_q - TMO_W'(1)) begin
                        state_d = StArm;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        capture_d = (state_d == StArm);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            cnt_cfg_q     <= '0;
            ivl_cfg_q     <= '0;
            tmo_cfg_q     <= '0;
            gap_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            ce_prev_q     <= 1'b0;
            capture_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frames_done_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_cfg_q     <= cnt_cfg_d;
            ivl_cfg_q     <= ivl_cfg_d;
            tmo_cfg_q     <= tmo_cfg_d;
            gap_cnt_q     <= gap_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            ce_prev_q     <= capture_end;
            capture_q     <= capture_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frames_done_q <= frames_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign capture     = capture_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_done = frames_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer; a narrow frame counter lets wrap-around be reached.
module tb_capture_sequencer;

    localparam int unsigned CW = 3;
    localparam int unsigned TW = 32;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] frame_count = '0;
    logic [TW-1:0] interval_cycles = '0;
    logic [TW-1:0] timeout_cycles = '0;
    logic          new_frame = 1'b0;
    logic          capture_end = 1'b0;
    logic          capture;
    logic          busy;
    logic          done;
    logic [CW-1:0] frames_done;
    logic          timeout_err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cap_cnt = 0;
    int lat;
    int d0;
    int c0;

    capture_sequencer #(
        .CNT_W(CW),
        .TMO_W(TW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .start          (start),
        .abort          (abort),
        .frame_count    (frame_count),
        .interval_cycles(interval_cycles),
        .timeout_cycles (timeout_cycles),
        .new_frame      (new_frame),
        .capture_end    (capture_end),
        .capture        (capture),
        .busy           (busy),
        .done           (done),
        .frames_done    (frames_done),
        .timeout_err    (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (capture === 1'b1) cap_cnt <= cap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    // Camera model: frame start clears capture_end, frame finishes dly cycles later
    task automatic frame(input int dly);
        new_frame   = 1'b1;
        capture_end = 1'b0;
        step();
        new_frame = 1'b0;
        repeat (dly) step();
        capture_end = 1'b1;
        step();
    endtask

    task automatic wait_cap(output int l);
        l = 1;
        while (capture !== 1'b1 && l < 40) begin
            step();
            l++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset state
        #2 sys_rst_n = 1'b0;
        step();
        chk("rst_capture", 32'(capture), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_frames_done", 32'(frames_done), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        sys_rst_n = 1'b1;
        step();

        // Three frames with a 10-cycle gap
        frame_count = 3; interval_cycles = 10; timeout_cycles = 0;
        d0 = done_cnt; c0 = cap_cnt;
        pulse_start();
        chk("seq_first_capture", 32'(capture), 1);
        chk("seq_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            frame(3);
            chk("seq_frames_done", 32'(frames_done), 32'(i + 1));
            if (i < 2) begin
                chk("seq_no_done", 32'(done), 0);
                wait_cap(lat);
                chk("seq_gap_latency", 32'(lat), 11);
            end else begin
                chk("seq_done_pulse", 32'(done), 1);
                chk("seq_busy_end", 32'(busy), 0);
            end
        end
        step();
        chk("seq_done_one_cycle", 32'(done), 0);
        chk("seq_done_count", 32'(done_cnt - d0), 1);
        chk("seq_capture_count", 32'(cap_cnt - c0), 3);

        // Start while busy is ignored; latched config stays in force
        frame_count = 2; interval_cycles = 0;
        pulse_start();
        frame_count = 1; interval_cycles = 5;
        pulse_start();
        chk("busy_start_no_capture", 32'(capture), 0);
        frame(2);
        chk("busy_start_not_done", 32'(done), 0);
        chk("busy_start_zero_gap", 32'(capture), 1);
        step();
        frame(2);
        chk("busy_start_done", 32'(done), 1);
        chk("busy_start_frames", 32'(frames_done), 2);
        step();

        // Watchdog expiry with no new_frame
        frame_count = 1; interval_cycles = 0; timeout_cycles = 100;
        capture_end = 1'b0;
        d0 = done_cnt;
        pulse_start();
        step();
        repeat (99) step();
        chk("wd_not_yet", 32'(timeout_err), 0);
        chk("wd_busy_before", 32'(busy), 1);
        step();
        chk("wd_expired", 32'(timeout_err), 1);
        chk("wd_busy_after", 32'(busy), 0);
        step();
        chk("wd_no_done", 32'(done_cnt - d0), 0);
        pulse_start();
        chk("wd_err_cleared", 32'(timeout_err), 0);
        chk("wd_restart_capture", 32'(capture), 1);
        pulse_abort();
        chk("wd_abort_idle", 32'(busy), 0);

        // capture_end rise on the very cycle the watchdog expires
        frame_count = 2; interval_cycles = 0; timeout_cycles = 20;
        pulse_start();
        step();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        repeat (18) step();
        capture_end = 1'b1;
        step();
        chk("tie_frames_done", 32'(frames_done), 1);
        chk("tie_timeout_err", 32'(timeout_err), 0);
        chk("tie_busy", 32'(busy), 1);
        pulse_abort();
        chk("tie_abort_capture", 32'(capture), 0);
        chk("tie_abort_busy", 32'(busy), 0);
        capture_end = 1'b0;
        step();

        // Continuous mode, abort after the fifth frame
        frame_count = 0; interval_cycles = 2; timeout_cycles = 0;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            step();
            frame(1);
            if (i < 4) begin
                wait_cap(lat);
                chk("cont_gap_latency", 32'(lat), 3);
            end
        end
        chk("cont_frames_before_abort", 32'(frames_done), 5);
        pulse_abort();
        chk("cont_abort_busy", 32'(busy), 0);
        chk("cont_abort_frames", 32'(frames_done), 5);
        step();
        step();
        chk("cont_abort_no_capture", 32'(capture), 0);
        chk("cont_abort_no_done", 32'(done_cnt - d0), 0);

        // Frame counter wraps modulo 2^CW
        frame_count = 0; interval_cycles = 0;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            step();
            frame(0);
        end
        chk("wrap_frames_done", 32'(frames_done), 1);
        pulse_abort();

        // Stale capture_end level must not count a frame
        frame_count = 1; interval_cycles = 0; timeout_cycles = 0;
        capture_end = 1'b1;
        step();
        pulse_start();
        step();
        capture_end = 1'b0;
        step();
        capture_end = 1'b1;
        step();
        chk("stale_rise_before_frame", 32'(frames_done), 0);
        chk("stale_busy", 32'(busy), 1);
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        repeat (3) step();
        chk("stale_level_after_frame", 32'(frames_done), 0);
        capture_end = 1'b0;
        step();
        capture_end = 1'b1;
        step();
        chk("stale_fresh_rise", 32'(frames_done), 1);
        chk("stale_done", 32'(done), 1);
        step();

        // Asynchronous reset in WAIT_END
        frame_count = 0; interval_cycles = 0; timeout_cycles = 0;
        capture_end = 1'b0;
        pulse_start();
        step();
        frame(1);
        step();
        new_frame   = 1'b1;
        capture_end = 1'b0;
        step();
        new_frame = 1'b0;
        step();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_capture", 32'(capture), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_frames_done", 32'(frames_done), 0);
        chk("arst_timeout_err", 32'(timeout_err), 0);
        step();
        step();
        sys_rst_n = 1'b1;
        repeat (3) step();
        chk("arst_stays_idle", 32'(busy), 0);
        pulse_start();
        chk("arst_restart_capture", 32'(capture), 1);
        pulse_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
